// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   CTRL_W      : ALU control code width
//   ALU_*       : supported control codes (ALU_ILLEGAL is a representative
//                 unsupported code; every code not listed is illegal)
//   alu_state_e : execute-unit sequencing state
`timescale 1ns/1ps
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_NOP     = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_AND     = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_OR      = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_ADD     = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SUB     = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_XOR     = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_MUL     = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_ILLEGAL = 4'b1000;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier datapath.
//   clk, reset : clock, synchronous active-high reset
//   start      : load a/b and clear accumulator/counter
//   run        : perform one shift-add step this cycle
//   a, b       : multiplicand / multiplier
//   done       : this cycle's step is the final one (valid only while run)
//   product    : low XLEN bits of a*b, valid when done
// Optional: ALU_MUL_EARLY_EXIT_EN finishes as soon as the remaining
// multiplier bits are all zero.
`timescale 1ns/1ps
module alu_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            run,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [CW-1:0]   cnt;
  logic            last;

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // The final step's accumulation is handed straight out as the product so
  // the owner can register it on the same edge the step completes.
  assign product = acc_next;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last = (mplier[XLEN-1:1] == '0) || (cnt == CW'(XLEN-1));
`else
  assign last = (cnt == CW'(XLEN-1));
`endif

  assign done = run && last;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : operation handshake (in_ctrl, in_a, in_b)
//   flush                 : drop in-flight operation and pending result
//   out_valid/out_ready   : result handshake
//   out_result            : registered result
//   out_zero, out_illegal : registered flags aligned with out_result
//   busy                  : multiplier iterating
// Single-cycle ops have latency 1; MUL uses alu_mul_iter.
// Optional: ALU_MUL_EARLY_EXIT_EN (see alu_mul_iter).
`timescale 1ns/1ps
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = alu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_zero,
  output logic              out_illegal,
  output logic              busy
);

  alu_state_e      state;
  logic            accept;
  logic            is_mul;
  logic            mul_start;
  logic            mul_run;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic [XLEN-1:0] op_res;
  logic            op_ill;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign busy      = (state == ST_MUL);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (in_ctrl == ALU_MUL);
  assign mul_start = accept && is_mul && !flush;
  assign mul_run   = (state == ST_MUL);

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (in_ctrl)
      ALU_AND: op_res = in_a & in_b;
      ALU_OR:  op_res = in_a | in_b;
      ALU_ADD: op_res = in_a + in_b;
      ALU_SUB: op_res = in_a - in_b;
      ALU_XOR: op_res = in_a ^ in_b;
      ALU_MUL: op_res = '0;
      ALU_NOP: op_res = '0;
      default: op_ill = 1'b1;
    endcase
  end

  alu_mul_iter #(
    .XLEN(XLEN)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .run    (mul_run),
    .a      (in_a),
    .b      (in_b),
    .done   (mul_done),
    .product(mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      // Consumption first; a same-cycle accept or completion overrides it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              out_valid   <= 1'b1;
              out_result  <= op_res;
              out_zero    <= (op_res == '0);
              out_illegal <= op_ill;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b1;
            out_result  <= mul_product;
            out_zero    <= (mul_product == '0);
            out_illegal <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
`timescale 1ns/1ps
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_ctrl;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_illegal;
  logic            busy;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ill;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  alu_exec_unit #(.XLEN(XLEN), .CTRL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_illegal(out_illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic from the operation table.
  function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    e.ill = 1'b0;
    case (c)
      4'd1:    e.res = a & b;
      4'd2:    e.res = a | b;
      4'd3:    e.res = a + b;
      4'd4:    e.res = a - b;
      4'd5:    e.res = a ^ b;
      4'd6:    e.res = a * b;
      4'd0:    e.res = '0;
      default: begin e.res = '0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic int exp_latency(input logic [3:0] c, input logic [XLEN-1:0] b);
    int m;
    if (c != 4'd6) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
    m = 0;
    for (int i = 0; i < XLEN; i++) if (b[i]) m = i + 1;
    return 1 + ((m < 1) ? 1 : m);
`else
    m = XLEN + 1;
    return m;
`endif
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  // Monitor: whenever a result is being consumed, compare with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      tot_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result: got res=0x%08h z=%b ill=%b expected none", out_result, out_zero, out_illegal);
      end else begin
        e = exp_q.pop_front();
        if (out_result === e.res && out_zero === e.zero && out_illegal === e.ill) pass_cnt++;
        else $display("FAIL result: got res=0x%08h z=%b ill=%b expected res=0x%08h z=%b ill=%b",
                      out_result, out_zero, out_illegal, e.res, e.zero, e.ill);
      end
    end
  end

  // Present an op and hold it until accepted; the expectation is queued on
  // the negedge before the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit rnd);
    bit accepted;
    int waited;
    accepted = 0;
    waited   = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(c, a, b));
        accepted = 1;
      end else begin
        waited++;
        @(posedge clk); #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!accepted) begin
      tot_cnt++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Directed op with out_ready high: checks latency and busy/in_ready while waiting.
  task automatic do_op(input string name, input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int lat, busy_cyc, bad;
    lat = 0; busy_cyc = 0; bad = 0;
    issue(c, a, b, 0);
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (busy) busy_cyc++;
      if (!busy || in_ready) bad++;
    end
    check({name, "_latency"}, lat, exp_latency(c, b));
    check({name, "_busy_cycles"}, busy_cyc, exp_latency(c, b) - 1);
    check({name, "_busy_inready_bad"}, bad, 0);
  endtask

  initial begin
    exp_t dropped;
    int   cnt;
    logic [3:0]      c;
    logic [XLEN-1:0] a, b;
    reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {out_zero, out_illegal}, 0);

    do_op("add", 4'd3, 32'h7FFF_FFFF, 32'h1);
    do_op("sub", 4'd4, 32'd5, 32'd5);
    do_op("xor", 4'd5, 32'h0000_F0F0, 32'h0000_0FF0);
    do_op("mul_ff", 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mul_6x3", 4'd6, 32'd6, 32'd3);
    do_op("mul_b0", 4'd6, 32'h1234_5678, 32'd0);
    do_op("mul_b1", 4'd6, 32'h1234_5678, 32'd1);
    do_op("illegal", 4'b1000, 32'd7, 32'd9);
    do_op("nop", 4'b0000, 32'd7, 32'd9);

    // Backpressure: AND result held, then consumed alongside a new OR accept.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(4'd1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 0);
    cnt = 0;
    while (!out_valid && cnt < 10) begin @(negedge clk); cnt++; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_hold_result", out_result, 32'hDEAD_BEEF & 32'h0F0F_0F0F);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 4'd2; in_a = 32'h00F0_0000; in_b = 32'h0000_000F;
    @(negedge clk);
    check("bp_same_cycle_accept", in_ready, 1);
    if (in_ready) exp_q.push_back(model(4'd2, 32'h00F0_0000, 32'h0000_000F));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid", out_valid, 1);

    // Flush in MUL cycle 10.
    issue(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    dropped = exp_q.pop_back();
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) cnt++; end
    check("flush_no_output", cnt, 0);

    // Flush in the same cycle as an accepting handshake: op ignored.
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 4'd3; in_a = 32'd1; in_b = 32'd2;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_accept_ignored", {out_valid, busy}, 0);

    // Reset in the middle of a MUL.
    issue(4'd6, 32'hFFFF_FFFF, 32'h0000_FFFF, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    dropped = exp_q.pop_back();
    @(negedge clk);
    check("rstmul_outputs", {out_valid, busy, out_zero, out_illegal}, 0);
    check("rstmul_result", out_result, 0);
    check("rstmul_in_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) cnt++; end
    check("rstmul_no_output", cnt, 0);

    // Randomized traffic with random consumer backpressure.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: c = 4'(1 + $urandom_range(0, 5));
        6:                c = 4'd0;
        default:          c = 4'($urandom_range(7, 15));
      endcase
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom();
      if ($urandom_range(0, 7) == 0) b = a;
      issue(c, a, b, 1);
    end

    @(posedge clk); #1 out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin @(negedge clk); cnt++; end
    check("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU fed by the ALU control decoder.
- Takes a 4-bit ALU control code plus two operands through a valid/ready handshake. Returns a registered result with zero and illegal flags.
- Logic ops and add/sub complete in one cycle. MUL runs an iterative shift-add multiplier over several cycles and backpressures the issue stage while busy.

Parameters:
- XLEN, 32, operand/result width.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation this cycle
- in_ctrl  input  CTRL_W  ALU control code
- in_a  input  XLEN  operand A (rs1)
- in_b  input  XLEN  operand B (rs2 or immediate)
- flush  input  1  discard in-flight operation and pending result
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_result  output  XLEN  result
- out_zero  output  1  out_result == 0
- out_illegal  output  1  control code not in the supported set
- busy  output  1  multiplier iterating

Behaviour:
- Reset (sync, active-high, clk edge): state IDLE; out_valid, out_result, out_zero, out_illegal, busy = 0; in_ready = 1 in the cycle after reset.
- Codes:
  - 0001 AND
  - 0010 OR
  - 0011 ADD
  - 0100 SUB
  - 0101 XOR
  - 0110 MUL (low XLEN bits of product)
  - 0000 NOP: result 0, illegal = 0
  - 1000 and every other code: result 0, illegal = 1
- Arithmetic: ADD/SUB wrap modulo 2^XLEN, no overflow flag. MUL is unsigned shift-add, truncated to XLEN bits. The low bits equal the signed product, so no sign handling is needed.
- Handshake:
  - An operation is accepted on a cycle where in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - A result is consumed on a cycle where out_valid && out_ready.
  - out_result and flags are held stable while out_valid && !out_ready.
- States:
  - IDLE: on accept of a non-MUL op, register the result and set out_valid next cycle (latency 1). On accept of MUL, load mcand = in_a, mplier = in_b, acc = 0, cnt = 0, then go to MUL.
  - MUL:
    - busy = 1 and in_ready = 0.
    - Each cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
    - When cnt reaches XLEN-1, write acc to out_result, set out_valid, and go to IDLE.
    - Latency is XLEN+1 cycles from accept; for XLEN = 32, out_valid rises 33 cycles after accept.
- Back-to-back: an op can be accepted in the same cycle the previous result is consumed. The new result replaces the old one on the next edge.
- flush: takes priority over accept and completion. It clears out_valid and busy and forces IDLE; the accepting handshake in the flush cycle is ignored.
- Simultaneous reset and flush: reset wins (same end state).
- Reset mid-MUL: abandon the iteration with no output produced.
- out_zero and out_illegal are registered together with out_result.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined: MUL completes at the end of the first MUL cycle after which the remaining mplier is 0. Latency = 1 + max(1, index_of_msb(in_b) + 1). in_b = 0 or 1 gives 2 cycles; in_b = 3 gives 3 cycles.
- Undefined: fixed XLEN+1 latency.
- Results are identical either way.

Decomposition:
- Package alu_pkg holds:
  - ALU control code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_MUL, ALU_NOP, ALU_ILLEGAL).
  - State enum (ST_IDLE, ST_MUL).
  - CTRL_W.
- One sub-module, alu_mul_iter, contains the iterative multiplier datapath and counter with start/done. alu_exec_unit keeps the handshake, the single-cycle ops and the output register.

Test Plan:
- Reset with out_ready = 1: out_valid = 0 and in_ready = 1 on the next cycle; out_result = 0.
- ADD 0x7FFFFFFF + 1 → 0x80000000 one cycle later. SUB 5 − 5 → 0, out_zero = 1. XOR 0xF0F0 ^ 0x0FF0 → 0xFF00.
- MUL 0xFFFFFFFF × 0xFFFFFFFF: busy for 32 cycles, in_ready = 0 throughout, out_result = 0x00000001 at cycle 33. With ALU_MUL_EARLY_EXIT_EN, 6 × 3 → 18 at cycle 3.
- Backpressure: hold out_ready = 0 after an AND result; result stays stable and in_ready = 0. Raise out_ready together with a new in_valid; the new op is accepted that cycle and its result appears the next cycle.
- Code 1000 with A = 7, B = 9 → out_result = 0, out_illegal = 1. Code 0000 → 0, out_illegal = 0.
- flush at MUL cycle 10 → busy = 0 and out_valid stays 0. Reset asserted mid-MUL → IDLE with all outputs 0 next cycle.
